control_stack: RTL
==================

Name: control_stack

Overview:
- Parametrised successor to the accumulator CPU control unit.
- Holds PC, IR and the fetch/execute FSM, and decodes the opcode to datapath strobes.
- Adds a full conditional-branch set, CALL/RETURN through an internal return-address stack of configurable depth, a HALT state and sticky stack-error flags.
- Sits between instruction memory, data memory and the accumulator/ALU datapath.

Parameters:
- OPERAND_WIDTH, 11, operand field width (IR[OPERAND_WIDTH-1:0]).
- INSTRUCTION_WIDTH, 16, instruction word width; opcode = IR[INSTRUCTION_WIDTH-1:OPERAND_WIDTH], 5 bits at default.
- ADDR_WIDTH, 11, PC/instruction address width, must be <= OPERAND_WIDTH; branch target = operand[ADDR_WIDTH-1:0].
- STACK_DEPTH, 4, return-address entries, >= 1.

Ports:
- clock_in, input, 1, system clock; all state updates on the rising edge.
- reset_in, input, 1, asynchronous active-low reset.
- instruction_in, input, INSTRUCTION_WIDTH, instruction memory read data; combinational from instruction_address_out.
- status_Z_in, input, 1, datapath zero flag (registered in datapath).
- status_N_in, input, 1, datapath negative flag.
- instruction_address_out, output, ADDR_WIDTH, PC value.
- operand_out, output, OPERAND_WIDTH, IR operand field.
- sel_A_out, output, 2, accumulator source: 00 ALU, 01 data memory, 10 operand.
- sel_B_out, output, 1, ALU B source: 0 data memory, 1 operand.
- alu_op_out, output, 1, 0 add, 1 sub.
- data_memory_wr_out, output, 1, data memory write strobe.
- acc_wr_out, output, 1, accumulator write.
- status_wr_out, output, 1, status register write.
- acc_reset_out, output, 1, accumulator clear.
- status_reset_out, output, 1, status register clear.
- halted_out, output, 1, FSM in HALT.
- stack_level_out, output, $clog2(STACK_DEPTH+1), current stack occupancy.
- stack_overflow_out, output, 1, sticky: CALL issued with stack full.
- stack_underflow_out, output, 1, sticky: RETURN issued with stack empty.

Behaviour:
- Async reset (reset_in=0):
  - PC=0, IR=0, stack pointer=0, error flags=0, FSM=INIT.
  - Strobes are decoded from state, so during reset acc_reset_out=status_reset_out=1 and all other strobes are 0.
- FSM states:
  - INIT: acc_reset_out=status_reset_out=1 for exactly one cycle after reset release -> FETCH.
  - FETCH: IR<=instruction_in, PC<=PC+1 (wraps 2^ADDR_WIDTH-1 -> 0), no datapath strobes -> EXECUTE.
  - EXECUTE: drive strobes for the opcode in IR (combinational from IR) -> FETCH, or -> HALT for HLT or a stack error.
  - HALT: all strobes 0, halted_out=1, PC/IR/stack frozen; exits only via reset.
- CPI is 2 for every instruction.
- Opcodes (5-bit) and EXECUTE actions; any strobe not listed is 0:
  - 00 HLT: enter HALT.
  - 01 STO: data_memory_wr.
  - 02 LD: sel_A=01, acc_wr, status_wr.
  - 03 LDI: sel_A=10, acc_wr, status_wr.
  - 04 ADD: sel_B=0, alu_op=0, sel_A=00, acc_wr, status_wr.
  - 05 ADDI: same as ADD with sel_B=1.
  - 06 SUB: same as ADD with alu_op=1.
  - 07 SUBI: same as SUB with sel_B=1.
  - 08 BEQ: condition Z.
  - 09 BNE: condition !Z.
  - 0A BGT: condition !Z & !N.
  - 0B BGE: condition !N.
  - 0C BLT: condition N.
  - 0D BLE: condition N | Z.
  - 0E JMP: unconditional.
  - 0F CALL: see stack rules below.
  - 10 RETURN: see stack rules below.
  - 11 NOP and 12-1F reserved: no action.
- Branches: condition uses status inputs sampled in EXECUTE; taken -> PC<=operand[ADDR_WIDTH-1:0], not taken -> PC unchanged (already incremented).
- CALL:
  - Not full: stack[sp]<=PC (address following the CALL), sp<=sp+1, PC<=target.
  - Full (sp==STACK_DEPTH): stack_overflow_out<=1, no push, PC unchanged, -> HALT.
- RETURN:
  - Not empty: PC<=stack[sp-1], sp<=sp-1.
  - Empty: stack_underflow_out<=1, PC unchanged, -> HALT.
- Stack is LIFO, no wrap; entries are not cleared on pop.
- Reset asserted mid-instruction aborts immediately to reset values; no partial memory write is held.

Test Plan:
- Reset release -> acc_reset_out=status_reset_out=1 for 1 cycle, then FETCH at address 0; PC reads 1 after first FETCH edge.
- Program at 0: LDI 5, ADDI 3, STO 7, HLT -> strobes exactly per table in each EXECUTE; halted_out=1 after cycle 8; PC frozen at 4.
- BEQ 0x20 with Z=1 -> PC=0x020; with Z=0 -> PC=next; repeat BGT with (Z,N)=(0,0) taken and (0,1) not taken; BLE with (1,0) taken.
- CALL 0x100 at address 0x010, then RETURN at 0x100 -> stack_level 1 then 0; next fetch address 0x011.
- Nested CALLs with STACK_DEPTH=4: 4 CALLs succeed (level 4); 5th CALL -> stack_overflow_out=1, HALT, level stays 4; RETURN at level 0 -> stack_underflow_out=1, HALT.
- PC wrap: NOP at 0x7FF -> next fetch at 0x000. Reset pulsed during EXECUTE of STO -> data_memory_wr_out drops immediately, all state returns to reset values.

Source files
------------

// File: rtl/control_stack.sv
// control_stack: PC/IR fetch-execute control unit with a conditional-branch set,
// CALL/RETURN through an internal return-address stack, HALT and sticky stack-error flags. Rev 1.0
`default_nettype none

module control_stack #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ADDR_WIDTH        = 11,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0]       instruction_in,
  input  logic                               status_Z_in,
  input  logic                               status_N_in,
  output logic [ADDR_WIDTH-1:0]              instruction_address_out,
  output logic [OPERAND_WIDTH-1:0]           operand_out,
  output logic [1:0]                         sel_A_out,
  output logic                               sel_B_out,
  output logic                               alu_op_out,
  output logic                               data_memory_wr_out,
  output logic                               acc_wr_out,
  output logic                               status_wr_out,
  output logic                               acc_reset_out,
  output logic                               status_reset_out,
  output logic                               halted_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level_out,
  output logic                               stack_overflow_out,
  output logic                               stack_underflow_out
);

  localparam int OPCODE_WIDTH = INSTRUCTION_WIDTH - OPERAND_WIDTH;
  localparam int LEVEL_WIDTH  = $clog2(STACK_DEPTH + 1);
  localparam int INDEX_WIDTH  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT    = OPCODE_WIDTH'(5'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO    = OPCODE_WIDTH'(5'h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD     = OPCODE_WIDTH'(5'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI    = OPCODE_WIDTH'(5'h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = OPCODE_WIDTH'(5'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = OPCODE_WIDTH'(5'h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB    = OPCODE_WIDTH'(5'h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = OPCODE_WIDTH'(5'h07);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ    = OPCODE_WIDTH'(5'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE    = OPCODE_WIDTH'(5'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT    = OPCODE_WIDTH'(5'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE    = OPCODE_WIDTH'(5'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT    = OPCODE_WIDTH'(5'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE    = OPCODE_WIDTH'(5'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = OPCODE_WIDTH'(5'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL   = OPCODE_WIDTH'(5'h0F);
  localparam logic [OPCODE_WIDTH-1:0] OP_RETURN = OPCODE_WIDTH'(5'h10);

  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL = LEVEL_WIDTH'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDR_WIDTH-1:0]    pc;
  logic [ADDR_WIDTH-1:0]    pc_next;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic [LEVEL_WIDTH-1:0]   sp;
  logic [ADDR_WIDTH-1:0]    stack_mem [STACK_DEPTH];
  logic                     ir_load;
  logic                     push;
  logic                     pop;
  logic                     overflow_set;
  logic                     underflow_set;
  logic                     overflow_flag;
  logic                     underflow_flag;
  logic                     branch_taken;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [ADDR_WIDTH-1:0]    target;
  logic [INDEX_WIDTH-1:0]   push_index;
  logic [INDEX_WIDTH-1:0]   pop_index;

  assign opcode     = ir[INSTRUCTION_WIDTH-1:OPERAND_WIDTH];
  assign target     = ir[ADDR_WIDTH-1:0];
  assign push_index = INDEX_WIDTH'(sp);
  assign pop_index  = INDEX_WIDTH'(sp - LEVEL_ONE);

  assign instruction_address_out = pc;
  assign operand_out             = ir[OPERAND_WIDTH-1:0];
  assign stack_level_out         = sp;
  assign stack_overflow_out      = overflow_flag;
  assign stack_underflow_out     = underflow_flag;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= ST_INIT;
      pc             <= '0;
      ir             <= '0;
      sp             <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= instruction_in;
      if (push) sp <= sp + LEVEL_ONE;
      else if (pop) sp <= sp - LEVEL_ONE;
      if (overflow_set) overflow_flag <= 1'b1;
      if (underflow_set) underflow_flag <= 1'b1;
    end
  end

  // Entries need no reset: the pointer alone defines which ones are valid.
  always_ff @(posedge clock_in) begin
    if (push) stack_mem[push_index] <= pc;
  end

  always_comb begin
    unique case (opcode)
      OP_BEQ:  branch_taken = status_Z_in;
      OP_BNE:  branch_taken = !status_Z_in;
      OP_BGT:  branch_taken = !status_Z_in && !status_N_in;
      OP_BGE:  branch_taken = !status_N_in;
      OP_BLT:  branch_taken = status_N_in;
      OP_BLE:  branch_taken = status_N_in || status_Z_in;
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    ir_load            = 1'b0;
    push               = 1'b0;
    pop                = 1'b0;
    overflow_set       = 1'b0;
    underflow_set      = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    acc_reset_out      = 1'b0;
    status_reset_out   = 1'b0;
    halted_out         = 1'b0;

    case (state)
      ST_INIT: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        state_next       = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load    = 1'b1;
        pc_next    = pc + ADDR_WIDTH'(1);
        state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_next = ST_FETCH;
        if (branch_taken) pc_next = target;
        case (opcode)
          OP_HLT: state_next = ST_HALT;
          OP_STO: data_memory_wr_out = 1'b1;
          OP_LD: begin
            sel_A_out     = 2'b01;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_LDI: begin
            sel_A_out     = 2'b10;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sel_B_out     = (opcode == OP_ADDI) || (opcode == OP_SUBI);
            alu_op_out    = (opcode == OP_SUB) || (opcode == OP_SUBI);
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_CALL: begin
            if (sp == LEVEL_FULL) begin
              overflow_set = 1'b1;
              state_next   = ST_HALT;
            end else begin
              push    = 1'b1;
              pc_next = target;
            end
          end
          OP_RETURN: begin
            if (sp == '0) begin
              underflow_set = 1'b1;
              state_next    = ST_HALT;
            end else begin
              pop     = 1'b1;
              pc_next = stack_mem[pop_index];
            end
          end
          default: ;
        endcase
      end
      ST_HALT: halted_out = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

endmodule

`default_nettype wire
